// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes,
// branch condition codes and PC-source selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExe    = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_t;

    localparam logic [4:0] OP_ALUR = 5'b00000;
    localparam logic [4:0] OP_ALUI = 5'b00001;
    localparam logic [4:0] OP_LI   = 5'b00010;
    localparam logic [4:0] OP_MOV  = 5'b00011;
    localparam logic [4:0] OP_LD   = 5'b00100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_BCC  = 5'b00110;
    localparam logic [4:0] OP_JMP  = 5'b00111;
    localparam logic [4:0] OP_CMP  = 5'b01000;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_CS = 3'b011;
    localparam logic [2:0] COND_CC = 3'b100;
    localparam logic [2:0] COND_MI = 3'b101;
    localparam logic [2:0] COND_PL = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_IMM = 2'b01;
    localparam logic [1:0] JMP_RM  = 2'b10;

    // True for every opcode the datapath implements (HLT included).
    function automatic logic is_defined_op(input logic [4:0] op);
        return (op <= OP_CMP) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction/flag inputs and datapath control outputs of the control unit.
interface control_fsm_if #(
    parameter int unsigned CNT_W = 16
);
    logic             TBorNot;
    logic [7:0]       InsM;
    logic [1:0]       InsL;
    logic [2:0]       PSW_NZC;
    logic [1:0]       Jump;
    logic             Branch, Buff_PC;
    logic             WBresource, PCplus1orWB, RBresource, WE_RF, LI;
    logic             oprandB, Flag, ALUop, Buff_PSW, Buff_OutR;
    logic             MEMresource, LIorMOV, ALUorNot, Buff_MEMIns, WE_MEM;
    logic             Halted, IllegalOp;
    logic [2:0]       State;
    logic [CNT_W-1:0] RetireCnt;

    // Control unit side.
    modport master (
        input  TBorNot, InsM, InsL, PSW_NZC,
        output Jump, Branch, Buff_PC,
        output WBresource, PCplus1orWB, RBresource, WE_RF, LI,
        output oprandB, Flag, ALUop, Buff_PSW, Buff_OutR,
        output MEMresource, LIorMOV, ALUorNot, Buff_MEMIns, WE_MEM,
        output Halted, IllegalOp, State, RetireCnt
    );

    // Datapath side.
    modport slave (
        output TBorNot, InsM, InsL, PSW_NZC,
        input  Jump, Branch, Buff_PC,
        input  WBresource, PCplus1orWB, RBresource, WE_RF, LI,
        input  oprandB, Flag, ALUop, Buff_PSW, Buff_OutR,
        input  MEMresource, LIorMOV, ALUorNot, Buff_MEMIns, WE_MEM,
        input  Halted, IllegalOp, State, RetireCnt
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Evaluates a branch condition code against the {N,Z,C} flags.
module branch_cond_eval
    import ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] psw_nzc,
    output logic       cond_met
);
    logic n_flag, z_flag, c_flag;
    assign {n_flag, z_flag, c_flag} = psw_nzc;

    // Pure decode of the condition code.
    always_comb begin
        cond_met = 1'b0;
        unique case (cond)
            COND_AL: cond_met = 1'b1;
            COND_EQ: cond_met = z_flag;
            COND_NE: cond_met = ~z_flag;
            COND_CS: cond_met = c_flag;
            COND_CC: cond_met = ~c_flag;
            COND_MI: cond_met = n_flag;
            COND_PL: cond_met = ~n_flag;
            COND_NV: cond_met = 1'b0;
            default: cond_met = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXE/MEM/WB sequencing with Moore
// control decode, testbench-ownership abort, HALT, sticky illegal-op flag
// and a retired-instruction counter.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned IDLE_ON_RST = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          clk,
    input  logic          Rst,
    control_fsm_if.master bus
);
    localparam state_t RstState = (IDLE_ON_RST != 0) ? StIdle : StFetch;

    state_t           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             last;
    logic             cond_met;
    logic [4:0]       op;

    assign op = bus.InsM[7:3];

    branch_cond_eval u_cond (
        .cond     (bus.InsM[2:0]),
        .psw_nzc  (bus.PSW_NZC),
        .cond_met (cond_met)
    );

    // State, sticky illegal flag and retire counter.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= RstState;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode && !is_defined_op(op)) illegal_q <= 1'b1;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Next state and per-state control decode.
    always_comb begin
        state_d         = state_q;
        last            = 1'b0;
        retire          = 1'b0;
        bus.Jump        = JMP_SEQ;
        bus.Branch      = 1'b0;
        bus.Buff_PC     = 1'b0;
        bus.WBresource  = 1'b0;
        bus.PCplus1orWB = 1'b0;
        bus.RBresource  = 1'b0;
        bus.WE_RF       = 1'b0;
        bus.LI          = 1'b0;
        bus.oprandB     = 1'b0;
        bus.Flag        = 1'b0;
        bus.ALUop       = 1'b0;
        bus.Buff_PSW    = 1'b0;
        bus.Buff_OutR   = 1'b0;
        bus.MEMresource = 1'b0;
        bus.LIorMOV     = 1'b0;
        bus.ALUorNot    = 1'b0;
        bus.Buff_MEMIns = 1'b0;
        bus.WE_MEM      = 1'b0;
        unique case (state_q)
            StIdle: if (!bus.TBorNot) state_d = StFetch;
            StFetch: begin
                bus.Buff_MEMIns = 1'b1;
                state_d         = StDecode;
            end
            StDecode: begin
                bus.Buff_OutR = 1'b1;
                state_d       = (op == OP_HLT) ? StHalt : StExe;
            end
            StExe: begin
                state_d = StMem;
                case (op)
                    OP_ALUR: begin
                        bus.ALUop    = bus.InsL[1];
                        bus.Flag     = bus.InsL[0];
                        bus.Buff_PSW = 1'b1;
                    end
                    OP_ALUI: begin
                        bus.oprandB  = 1'b1;
                        bus.ALUop    = bus.InsL[0];
                        bus.Buff_PSW = 1'b1;
                    end
                    OP_LI, OP_MOV: bus.LI = 1'b1;
                    OP_LD, OP_ST:  bus.oprandB = 1'b1;
                    OP_BCC: begin
                        bus.Buff_PC = 1'b1;
                        bus.Branch  = cond_met;
                        last        = 1'b1;
                    end
                    OP_JMP: begin
                        // InsL[0] picks register target, InsL[1] links into RF.
                        bus.Buff_PC = 1'b1;
                        bus.Jump    = bus.InsL[0] ? JMP_RM : JMP_IMM;
                        bus.WE_RF   = bus.InsL[1];
                        last        = 1'b1;
                    end
                    OP_CMP: begin
                        bus.ALUop    = 1'b1;
                        bus.Buff_PSW = 1'b1;
                        bus.Buff_PC  = 1'b1;
                        last         = 1'b1;
                    end
                    default: begin
                        bus.Buff_PC = 1'b1;
                        last        = 1'b1;
                    end
                endcase
            end
            StMem: begin
                state_d = StWb;
                case (op)
                    OP_LI:  bus.ALUorNot = 1'b1;
                    OP_MOV: begin
                        bus.ALUorNot = 1'b1;
                        bus.LIorMOV  = 1'b1;
                    end
                    OP_LD:  bus.MEMresource = 1'b1;
                    OP_ST: begin
                        bus.MEMresource = 1'b1;
                        bus.WE_MEM      = 1'b1;
                        bus.Buff_PC     = 1'b1;
                        last            = 1'b1;
                    end
                    OP_ALUR, OP_ALUI: ;
                    default: last = 1'b1;
                endcase
            end
            StWb: begin
                last        = 1'b1;
                bus.WE_RF   = 1'b1;
                bus.Buff_PC = 1'b1;
                if (op == OP_LD) begin
                    bus.WBresource = 1'b1;
                    bus.RBresource = 1'b1;
                end else begin
                    bus.PCplus1orWB = 1'b1;
                end
            end
            StHalt: ;
            default: state_d = RstState;
        endcase
        if (last) begin
            state_d = StFetch;
            retire  = 1'b1;
        end
        // Testbench taking memory back aborts the instruction with no side effects.
        if (bus.TBorNot && state_q != StHalt && state_q != StIdle) begin
            state_d     = StIdle;
            retire      = 1'b0;
            bus.Buff_PC = 1'b0;
            bus.WE_RF   = 1'b0;
            bus.WE_MEM  = 1'b0;
        end
    end

    assign bus.Halted    = (state_q == StHalt);
    assign bus.IllegalOp = illegal_q;
    assign bus.State     = state_q;
    assign bus.RetireCnt = cnt_q;
endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multicycle control unit for the 16-bit RISC datapath. It drives every datapath control input: PC, register-file/ALU and memory steering, and buffer enables.
- Inputs are the latched instruction fields (InsM = Ins[15:8], InsL = Ins[1:0]) and the PSW flags PSW_NZC.
- Sequences each instruction through FETCH/DECODE/EXE/MEM/WB.
- Holds in IDLE while the testbench owns memory, and stops in HALT on HLT.

Parameters:
- IDLE_ON_RST, 1, after reset enter IDLE (1) or go straight to FETCH (0).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- TBorNot  in  1  1 = testbench owns memory; FSM held in IDLE
- InsM  in  8  instruction bits [15:8]; opcode = InsM[15:11], cond = InsM[10:8]
- InsL  in  2  instruction bits [1:0]; funct
- PSW_NZC  in  3  {N,Z,C}
- Jump  out  2  00 seq/branch, 01 PC+imm, 10 Rm
- Branch  out  1  take PC-relative branch
- Buff_PC  out  1  PC register enable
- WBresource, PCplus1orWB, RBresource, WE_RF, LI, oprandB, Flag, ALUop, Buff_PSW, Buff_OutR  out  1 each  RF/ALU controls
- MEMresource, LIorMOV, ALUorNot, Buff_MEMIns, WE_MEM  out  1 each  memory controls
- Halted  out  1  FSM in HALT
- IllegalOp  out  1  sticky, set on undefined opcode
- State  out  3  current state encoding
- RetireCnt  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- Reset: State = IDLE (or FETCH if IDLE_ON_RST = 0). All control outputs, Halted, IllegalOp and RetireCnt = 0.
- Output structure: outputs are Moore, decoded from State and the current InsM/InsL. The Ins register changes only on Buff_MEMIns, so decode is stable after FETCH. Any control not listed for a state is 0.
- IDLE: while TBorNot = 1, stay in IDLE. When TBorNot = 0, go to FETCH next cycle.
- TBorNot rising in any non-HALT state: abort the instruction. Next state is IDLE; no Buff_PC, WE_RF or WE_MEM in that cycle.
- FETCH: MEMresource=0, Buff_MEMIns=1. Next state DECODE.
- DECODE: Buff_OutR=1. Next state EXE, or HALT if opcode=HLT.
- Opcode 00000 ALU-R (InsL: 00 ADD, 01 ADC, 10 SUB, 11 SBB):
  - EXE: ALUop=InsL[1], Flag=InsL[0], oprandB=0, Buff_PSW=1.
  - MEM: ALUorNot=0.
  - WB: PCplus1orWB=1, WBresource=0, WE_RF=1, Buff_PC=1.
  - Total 5 cycles.
- Opcode 00001 ALU-I: same as ALU-R but oprandB=1, ALUop=InsL[0], Flag=0.
- Opcode 00010 LI: EXE LI=1; MEM ALUorNot=1, LIorMOV=0; WB as ALU. 5 cycles.
- Opcode 00011 MOV: as LI but LIorMOV=1 in MEM.
- Opcode 00100 LD:
  - EXE: address add (oprandB=1).
  - MEM: MEMresource=1.
  - WB: WBresource=1, RBresource=1, WE_RF=1, Buff_PC=1.
  - 5 cycles.
- Opcode 00101 ST:
  - EXE: address add.
  - MEM: MEMresource=1, WE_MEM=1, Buff_PC=1.
  - 4 cycles; no RF write.
- Opcode 00110 Bcc:
  - EXE: Buff_PC=1, Jump=00, Branch=cond_met. 3 cycles.
  - cond: 000 AL, 001 EQ (Z), 010 NE (!Z), 011 CS (C), 100 CC (!C), 101 MI (N), 110 PL (!N), 111 NV.
- Opcode 00111 jump group (EXE only, 3 cycles, Buff_PC=1):
  - InsL 00 J: Jump=01.
  - InsL 01 JR: Jump=10.
  - InsL 10 JAL: Jump=01, plus WE_RF=1, PCplus1orWB=0.
  - InsL 11 JALR: Jump=10, plus WE_RF=1, PCplus1orWB=0.
- Opcode 01000 CMP: EXE ALUop=1, Buff_PSW=1, Buff_PC=1. 3 cycles; no RF write.
- Opcode 11111 HLT: go to HALT. Halted=1, PC not advanced, no writes. Leave only via Rst.
- Undefined opcode: set IllegalOp. Treat as NOP: EXE with Buff_PC=1, 3 cycles.
- After the last state of any instruction, go to FETCH and increment RetireCnt by 1. HLT does not count.
- Rst mid-instruction: immediate return to the reset state. No partial write is issued after Rst asserts.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings: IDLE=0, FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5, HALT=6.
  - opcode constants and cond codes.
  - Jump encodings JMP_SEQ, JMP_IMM, JMP_RM.
- Sub-module branch_cond_eval: combinational (cond, PSW_NZC) -> cond_met.

Test Plan:
- Rst, TBorNot=1 for 10 cycles, then 0 -> State holds IDLE(0), then FETCH(1). Buff_MEMIns=1 exactly in FETCH; all other outputs 0.
- ADD (InsM=8'h00, InsL=00) -> states F,D,E,M,W. Buff_PSW=1 only in E. WE_RF=1 and Buff_PC=1 only in W. RetireCnt 0->1.
- ST (InsM=8'h28) -> WE_MEM=1 and MEMresource=1 in MEM. WE_RF never asserted. Next state FETCH after 4 cycles.
- BEQ (InsM=8'h31) with PSW_NZC=3'b010 -> Branch=1 in EXE. With PSW_NZC=3'b000 -> Branch=0, Buff_PC=1 either way.
- JAL (InsM=8'h38, InsL=10) -> EXE Jump=01, WE_RF=1, PCplus1orWB=0. Undefined InsM=8'h50 -> IllegalOp=1 and stays 1; FSM continues.
- HLT (InsM=8'hF8) -> HALT, Halted=1, stays 20 cycles; assert Rst in the middle of a LD MEM state -> State=IDLE immediately, WE_RF never asserted.
